// File: rtl/phys_mem_arb.sv
// Two-port physical memory arbiter: fetch and data share one fixed-latency memory.
// Optional fetch starvation guard enabled by defining PHYS_ARB_STARVE_GUARD_EN.
module phys_mem_arb #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ready,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic [3:0]        m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    logic               grant_f;
    logic               grant_d;
    logic               force_f;
    logic               rd_new;
    logic [MEM_LAT-1:0] pipe_vld;
    logic [MEM_LAT-1:0] pipe_port;

`ifdef PHYS_ARB_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign force_f = f_req && (starve_cnt == CNT_W'(STARVE_MAX));

    // Counts consecutive enabled cycles in which a pending fetch lost arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (clk_en) begin
            if (!f_req || f_ready) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_starve_cfg;

    assign force_f           = 1'b0;
    assign unused_starve_cfg = ^STARVE_MAX;
`endif

    always_comb begin
        grant_d = d_req & ~force_f;
        grant_f = f_req & ~grant_d;
        f_ready = grant_f & clk_en;
        d_ready = grant_d & clk_en;
        m_en    = f_ready | d_ready;
        m_addr  = '0;
        m_we    = '0;
        m_wdata = '0;
        if (d_ready) begin
            m_addr  = d_addr;
            m_we    = d_we;
            m_wdata = d_wdata;
        end else if (f_ready) begin
            m_addr = f_addr;
        end
        rd_new = f_ready | (d_ready & (d_we == 4'b0000));
    end

    // Tag pipeline tracks which port owns each in-flight read; port bit 1 means data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld  <= '0;
            pipe_port <= '0;
        end else if (clk_en) begin
            for (int i = MEM_LAT - 1; i > 0; i--) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_port[i] <= pipe_port[i-1];
            end
            pipe_vld[0]  <= rd_new;
            pipe_port[0] <= d_ready;
        end
    end

    assign f_rvalid = pipe_vld[MEM_LAT-1] & ~pipe_port[MEM_LAT-1];
    assign d_rvalid = pipe_vld[MEM_LAT-1] &  pipe_port[MEM_LAT-1];
    assign f_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule
